// File: rtl/rcr_pkg.sv
// Shared types and helpers for the ripple count reader: FSM states,
// delta saturation and the timestamp width.
package rcr_pkg;

    localparam int TS_WIDTH = 16;

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        PEND
    } state_t;

    // Clamp a merged delta into the (size+1)-bit two's-complement range.
    function automatic int sat_delta(input int sum, input int size);
        int hi;
        int lo;
        hi = (1 << size) - 1;
        lo = -(1 << size);
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/rcr_sync_filter.sv
// Two-flop synchroniser plus stability filter for the asynchronous ripple count;
// emits a one-cycle accept pulse when a value has been held long enough.
module rcr_sync_filter #(
    parameter int SIZE          = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] cnt_in,
    output logic [SIZE-1:0] value,
    output logic            accept
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

    logic [SIZE-1:0] s1;
    logic [SIZE-1:0] s2;
    logic [SIZE-1:0] prev;
    logic [2:0]      fill;
    logic [SW-1:0]   stab;
    logic            held;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
            fill <= '0;
            stab <= '0;
            held <= 1'b0;
        end else begin
            s1   <= cnt_in;
            s2   <= s1;
            prev <= s2;
            // Cleared pipeline stages must not count as matching samples.
            fill <= {fill[1:0], 1'b1};
            if (fill[2] && (s2 == prev))
                stab <= (stab == STAB_MAX) ? stab : stab + 1'b1;
            else
                stab <= '0;
            held <= (stab == STAB_MAX);
        end
    end

    assign value  = prev;
    assign accept = (stab == STAB_MAX) && !held;

endmodule

// File: rtl/ripple_count_reader.sv
// Clocked reader for an asynchronous ripple counter: reports settled changes as
// count + saturating delta snapshots. Optional RCR_TIMESTAMP_EN adds out_time.
module ripple_count_reader
    import rcr_pkg::*;
#(
    parameter int SIZE          = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] cnt_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_count,
    output logic [SIZE:0]   out_delta,
    output logic            out_overrun
`ifdef RCR_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0] out_time
`endif
);

    typedef logic signed [SIZE:0] delta_t;

    state_t          state, state_n;
    logic [SIZE-1:0] base, base_n;
    logic [SIZE-1:0] count_n;
    delta_t          delta_q, delta_n;
    logic            valid_n;
    logic            overrun_n;
    logic            load;

    logic [SIZE-1:0] acc_value;
    logic            accept;
    logic [SIZE-1:0] diff;
    delta_t          step;
    delta_t          merged;
    logic            fresh;

    rcr_sync_filter #(
        .SIZE          (SIZE),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .value  (acc_value),
        .accept (accept)
    );

    // Modular difference reinterpreted as signed handles wrap in both directions.
    assign diff   = acc_value - base;
    assign step   = {diff[SIZE-1], diff};
    assign merged = delta_t'(sat_delta(int'(delta_q) + int'(step), SIZE));
    assign fresh  = accept && (acc_value != base);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_n   = state;
        base_n    = base;
        count_n   = out_count;
        delta_n   = delta_q;
        valid_n   = out_valid;
        overrun_n = out_overrun;
        load      = 1'b0;
        case (state)
            ACQUIRE: begin
                if (accept) begin
                    base_n  = acc_value;
                    state_n = TRACK;
                end
            end
            TRACK: begin
                if (fresh) begin
                    count_n = acc_value;
                    delta_n = step;
                    base_n  = acc_value;
                    valid_n = 1'b1;
                    load    = 1'b1;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (out_ready) begin
                    if (fresh) begin
                        count_n   = acc_value;
                        delta_n   = step;
                        base_n    = acc_value;
                        overrun_n = 1'b0;
                        load      = 1'b1;
                    end else begin
                        valid_n   = 1'b0;
                        overrun_n = 1'b0;
                        state_n   = TRACK;
                    end
                end else if (fresh) begin
                    count_n   = acc_value;
                    delta_n   = merged;
                    base_n    = acc_value;
                    overrun_n = 1'b1;
                    load      = 1'b1;
                end
            end
            default: state_n = ACQUIRE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACQUIRE;
            base        <= '0;
            out_count   <= '0;
            delta_q     <= '0;
            out_valid   <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            base        <= base_n;
            out_count   <= count_n;
            delta_q     <= delta_n;
            out_valid   <= valid_n;
            out_overrun <= overrun_n;
        end
    end

    assign out_delta = delta_q;

`ifdef RCR_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt   <= '0;
            out_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (load)
                out_time <= ts_cnt;
        end
    end
`else
    logic unused_load;
    assign unused_load = load;
`endif

endmodule
